// File: rtl/switch_conditioner_if.sv
// Switch conditioner bus: raw switch inputs and acknowledge in, conditioned levels/strobes/events out.
// Pure signal bundle; no storage, no latency of its own.
// No backpressure: all outputs are levels or single-cycle pulses.
interface switch_conditioner_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic             ack;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] event_bits;
  logic             event_pending;

  // Board/driver side: presents raw switches and acknowledge, observes results.
  modport master (
    output sw_raw,
    output ack,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  event_bits,
    input  event_pending
  );

  // Conditioner side.
  modport slave (
    input  sw_raw,
    input  ack,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output event_bits,
    output event_pending
  );
endinterface

// File: rtl/switch_conditioner.sv
// Synchronizes and debounces raw board switches; emits rise/fall strobes and sticky change events.
// Latency: raw change sampled at edge k is visible on sw_clean at edge k+1+DEBOUNCE_CYCLES.
// No backpressure: event_bits is held until ack; a new event coincident with ack is kept.
module switch_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  switch_conditioner_if.slave  sw_if
);

  // Counter value at which a held difference is finally accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q,  rise_d;
  logic [WIDTH-1:0] fall_q,  fall_d;
  logic [WIDTH-1:0] event_q, event_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Two-flop synchronizer chain; only sync2 is trusted downstream.
  always_comb begin
    sync1_d = sw_if.sw_raw;
    sync2_d = sync1_q;
  end

  // Per-bit stability counters: count cycles that sync2 disagrees with the accepted level,
  // restart on any agreement, and accept the new level when the count completes.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Sticky events: ack clears old history, but anything accepted this cycle survives.
  always_comb begin
    event_d = (sw_if.ack ? '0 : event_q) | rise_d | fall_d;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Debounce counters; cleared by reset so a mid-debounce reset restarts counting from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Accepted levels, registered strobes and sticky event bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
    end else begin
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign sw_if.sw_clean      = clean_q;
  assign sw_if.sw_rise       = rise_q;
  assign sw_if.sw_fall       = fall_q;
  assign sw_if.event_bits    = event_q;
  assign sw_if.event_pending = |event_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: two instances (DEBOUNCE_CYCLES=4 and =1) against a history-based model.
// Directed scenarios first, then randomized switch activity with random acks.
// Model runs on posedge, comparisons happen on negedge.
module tb_switch_conditioner;

  logic clk;
  logic rst_n;

  switch_conditioner_if #(.WIDTH(8)) ifa ();
  switch_conditioner_if #(.WIDTH(8)) ifb ();

  switch_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .sw_if (ifa)
  );

  switch_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .CNT_W(16)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .sw_if (ifb)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // A bit's clean level flips when the last D synchronized samples all differ from it.
  logic [7:0] m_s1    [2];
  logic [7:0] m_s2    [2];
  logic [7:0] m_clean [2];
  logic [7:0] m_rise  [2];
  logic [7:0] m_fall  [2];
  logic [7:0] m_ev    [2];
  logic [7:0] hist    [2][16];

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_s1[id] = '0; m_s2[id] = '0; m_clean[id] = '0;
      m_rise[id] = '0; m_fall[id] = '0; m_ev[id] = '0;
      for (int k = 0; k < 16; k++) hist[id][k] = '0;
    end
  endtask

  task automatic model_step(input int id, input int d, input logic [7:0] raw, input logic a);
    logic [7:0] nc, r, f;
    bit all_diff;
    for (int k = 15; k > 0; k--) hist[id][k] = hist[id][k-1];
    hist[id][0] = m_s2[id];
    nc = m_clean[id];
    r = '0;
    f = '0;
    for (int b = 0; b < 8; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < d; j++)
        if (hist[id][j][b] == m_clean[id][b]) all_diff = 1'b0;
      if (all_diff) begin
        nc[b] = ~m_clean[id][b];
        if (nc[b]) r[b] = 1'b1; else f[b] = 1'b1;
      end
    end
    m_ev[id]    = (a ? 8'h00 : m_ev[id]) | r | f;
    m_rise[id]  = r;
    m_fall[id]  = f;
    m_clean[id] = nc;
    m_s2[id]    = m_s1[id];
    m_s1[id]    = raw;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, 4, ifa.sw_raw, ifa.ack);
      model_step(1, 1, ifb.sw_raw, ifb.ack);
    end
  end

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_clean", {24'd0, ifa.sw_clean},   {24'd0, m_clean[0]});
      check("a_rise",  {24'd0, ifa.sw_rise},    {24'd0, m_rise[0]});
      check("a_fall",  {24'd0, ifa.sw_fall},    {24'd0, m_fall[0]});
      check("a_event", {24'd0, ifa.event_bits}, {24'd0, m_ev[0]});
      check("a_pend",  {31'd0, ifa.event_pending}, {31'd0, |m_ev[0]});
      check("b_clean", {24'd0, ifb.sw_clean},   {24'd0, m_clean[1]});
      check("b_rise",  {24'd0, ifb.sw_rise},    {24'd0, m_rise[1]});
      check("b_fall",  {24'd0, ifb.sw_fall},    {24'd0, m_fall[1]});
      check("b_event", {24'd0, ifb.event_bits}, {24'd0, m_ev[1]});
      check("b_pend",  {31'd0, ifb.event_pending}, {31'd0, |m_ev[1]});
    end
  end

  task automatic check_a_zero(input string tag);
    check({tag, "_clean"}, {24'd0, ifa.sw_clean},   32'd0);
    check({tag, "_rise"},  {24'd0, ifa.sw_rise},    32'd0);
    check({tag, "_fall"},  {24'd0, ifa.sw_fall},    32'd0);
    check({tag, "_event"}, {24'd0, ifa.event_bits}, 32'd0);
    check({tag, "_pend"},  {31'd0, ifa.event_pending}, 32'd0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0] seen;
    int lat;
    int hold_a, hold_b;

    rst_n = 1'b0;
    ifa.sw_raw = 8'hFF; ifa.ack = 1'b0;
    ifb.sw_raw = 8'h00; ifb.ack = 1'b0;

    // Reset held with switches high: everything stays zero.
    repeat (3) @(negedge clk);
    check_a_zero("rst");

    // Release and count edges to acceptance.
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      if (e == 5) check("pwr_e5_clean", {24'd0, ifa.sw_clean}, 32'h00);
      if (e == 6) begin
        check("pwr_e6_clean", {24'd0, ifa.sw_clean},   32'hFF);
        check("pwr_e6_rise",  {24'd0, ifa.sw_rise},    32'hFF);
        check("pwr_e6_event", {24'd0, ifa.event_bits}, 32'hFF);
        check("pwr_e6_pend",  {31'd0, ifa.event_pending}, 32'd1);
      end
      if (e == 7) check("pwr_e7_rise", {24'd0, ifa.sw_rise}, 32'h00);
    end

    // Acknowledge clears events.
    ifa.ack = 1'b1;
    @(negedge clk);
    ifa.ack = 1'b0;
    check("ack_event", {24'd0, ifa.event_bits}, 32'h00);
    check("ack_pend",  {31'd0, ifa.event_pending}, 32'd0);

    // Drop bit 7.
    ifa.sw_raw = 8'h7F;
    lat = 0;
    while (lat < 12 && ifa.sw_fall == 8'h00) begin
      @(negedge clk);
      lat++;
    end
    check("fall_lat",   lat, 6);
    check("fall_val",   {24'd0, ifa.sw_fall},    32'h80);
    check("fall_event", {24'd0, ifa.event_bits}, 32'h80);
    @(negedge clk);
    check("fall_once",  {24'd0, ifa.sw_fall},    32'h00);

    // Settle at 00 and clear events, then glitch bit 0 five times.
    ifa.sw_raw = 8'h00;
    repeat (8) @(negedge clk);
    ifa.ack = 1'b1;
    @(negedge clk);
    ifa.ack = 1'b0;
    seen = 8'h00;
    for (int n = 0; n < 5; n++) begin
      ifa.sw_raw = 8'h01;
      repeat (3) begin
        @(negedge clk);
        seen |= ifa.sw_clean | ifa.sw_rise | ifa.sw_fall | ifa.event_bits;
      end
      ifa.sw_raw = 8'h00;
      repeat (3) begin
        @(negedge clk);
        seen |= ifa.sw_clean | ifa.sw_rise | ifa.sw_fall | ifa.event_bits;
      end
    end
    repeat (4) begin
      @(negedge clk);
      seen |= ifa.sw_clean | ifa.sw_rise | ifa.sw_fall | ifa.event_bits;
    end
    check("glitch_quiet", {24'd0, seen}, 32'h00);

    // event_bits=01, then ack exactly when rise[3] fires.
    ifa.sw_raw = 8'h01;
    repeat (8) @(negedge clk);
    check("pre_ack_event", {24'd0, ifa.event_bits}, 32'h01);
    ifa.sw_raw = 8'h09;
    repeat (5) @(negedge clk);
    ifa.ack = 1'b1;
    @(negedge clk);
    ifa.ack = 1'b0;
    check("ackrise_rise",  {24'd0, ifa.sw_rise},    32'h08);
    check("ackrise_event", {24'd0, ifa.event_bits}, 32'h08);
    check("ackrise_clean", {24'd0, ifa.sw_clean},   32'h09);

    // Asynchronous reset in the middle of a debounce.
    @(negedge clk);
    ifa.sw_raw = 8'h0F;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_a_zero("areset");
    ifa.sw_raw = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_clean", {24'd0, ifa.sw_clean},   32'h00);
    check("post_rst_event", {24'd0, ifa.event_bits}, 32'h00);

    // Single-cycle debounce instance.
    ifb.sw_raw = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    check("d1_e2_clean", {24'd0, ifb.sw_clean}, 32'h00);
    @(negedge clk);
    check("d1_e3_clean", {24'd0, ifb.sw_clean}, 32'hA5);
    check("d1_e3_rise",  {24'd0, ifb.sw_rise},  32'hA5);
    @(negedge clk);
    check("d1_e4_rise",  {24'd0, ifb.sw_rise},  32'h00);

    // Randomized activity: held values, occasional single-cycle glitches, random acks.
    hold_a = 0;
    hold_b = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_a == 0) begin
        ifa.sw_raw = 8'($urandom);
        hold_a = $urandom_range(1, 10);
      end else begin
        hold_a--;
        if ($urandom_range(0, 15) == 0)
          ifa.sw_raw = ifa.sw_raw ^ (8'd1 << $urandom_range(0, 7));
      end
      if (hold_b == 0) begin
        ifb.sw_raw = 8'($urandom);
        hold_b = $urandom_range(1, 3);
      end else begin
        hold_b--;
      end
      ifa.ack = ($urandom_range(0, 7) == 0);
      ifb.ack = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    ifa.ack = 1'b0;
    ifb.ack = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the external memory block's switches port.
- Takes raw, asynchronous, bouncing board switches and produces per-bit synchronized, debounced levels; this vector is what the memory-mapped switch address returns to the MiniMIPS core.
- Also generates single-cycle rise/fall strobes and a sticky change-event register with acknowledge, so software or a later interrupt stage can detect switch activity.

Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a level change is accepted; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of each per-bit stability counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  raw board switches, asynchronous to clk.
- ack  input  1  clears event_bits (synchronous, single-cycle pulse or level).
- sw_clean  output  WIDTH  debounced switch levels; connects to exmem switches.
- sw_rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1 change.
- sw_fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0 change.
- event_bits  output  WIDTH  sticky per-bit "changed since last ack".
- event_pending  output  1  OR-reduction of event_bits.

Behaviour:
- Reset (reset low, asynchronous, effective immediately, including mid-debounce):
  - Sync flops, counters, sw_clean, sw_rise, sw_fall and event_bits all go to 0; event_pending is therefore 0.
  - Counters restart from 0 after reset deasserts.
- Synchronizer: two-flop chain per bit (sync1 <= sw_raw, sync2 <= sync1). Only sync2 feeds the logic below.
- Per-bit debounce, evaluated independently on each rising edge:
  - sync2 == sw_clean: counter <= 0, no change.
  - sync2 != sw_clean and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != sw_clean and counter == DEBOUNCE_CYCLES-1: sw_clean <= sync2, counter <= 0.
- Latency: a raw change first sampled into sync1 at edge k appears on sw_clean at edge k+1+DEBOUNCE_CYCLES, provided it is held stable throughout.
- Glitch rejection:
  - Any return of sync2 to the sw_clean value before the count completes resets that bit's counter to 0.
  - A pulse shorter than DEBOUNCE_CYCLES synchronized cycles never reaches sw_clean.
- Strobes: sw_rise/sw_fall are registered and high for exactly the one cycle in which the new sw_clean value is first visible; 0 otherwise. Rise and fall are never high together for one bit.
- Event register, each edge: event_bits <= (ack ? 0 : event_bits) | sw_rise_next | sw_fall_next.
  - A new event in the same cycle as ack is retained.
  - Bits with no new event are cleared.
- event_pending is derived from the event_bits register; it carries no extra latency.
- Counter width: CNT_W is sized so DEBOUNCE_CYCLES-1 is representable; the counter never wraps.
- Multiple bits may change in the same cycle; each is handled independently with no priority.

Test Plan:
- DEBOUNCE_CYCLES=4. Hold reset low, sw_raw=8'hFF -> all outputs 0. Release reset, hold 8'hFF -> sw_clean=8'hFF at the 6th edge after release (2 sync + 4 stable), sw_rise=8'hFF for exactly that one cycle, event_bits=8'hFF, event_pending=1.
- From sw_clean=8'h00, toggle sw_raw[0] 1 for 3 cycles then 0, repeated 5 times -> sw_clean stays 8'h00, no strobes, event_bits stays 8'h00.
- sw_clean=8'hFF, event_bits=8'hFF. Pulse ack -> event_bits=8'h00, pending=0. Then set sw_raw=8'h7F -> sw_fall=8'h80 for one cycle, event_bits=8'h80.
- Assert ack in the same cycle sw_rise[3] fires, with event_bits=8'h01 beforehand -> event_bits=8'h08 next cycle.
- Set sw_raw=8'h0F for 3 synchronized cycles, then assert reset low asynchronously between edges -> all outputs 0 immediately. After release with 8'h00 held -> sw_clean remains 8'h00.
- DEBOUNCE_CYCLES=1. Change sw_raw 8'h00->8'hA5 -> sw_clean=8'hA5 two edges after the sampling edge, sw_rise=8'hA5 for one cycle.
